lsu_mem_initiator: RTL and testbench
====================================

Name: lsu_mem_initiator

Overview:
- CPU-side load/store unit for the RISC-V core. It issues requests to the data memory system through MemRead, MemWrite, WA, Data_in, stall and Data_out.
- Converts byte addresses plus funct3 into word accesses.
- Loads: sign- or zero-extends sub-word results.
- Sub-word stores: performs read-modify-write, because the memory side writes whole 32-bit words only.
- Holds the core through cache misses using the stall handshake.

Parameters:
- ADDR_W, 10, word-address width driven on WA.
- XLEN, 32, data width of requests and memory.

Ports:
- clk  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- req_valid  in  1  request strobe. Sampled only when busy=0.
- req_write  in  1  1=store, 0=load.
- funct3  in  3  RISC-V width code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- addr  in  32  byte address.
- wdata  in  XLEN  store data, taken from the low bits.
- busy  out  1  high while a transaction is in flight.
- done  out  1  one-cycle completion pulse.
- rdata  out  XLEN  extended load result. Valid while done=1 and held afterwards.
- err  out  1  one-cycle pulse for an illegal funct3 (011, 110, 111) or a misaligned access (see Optional Feature).
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- WA  out  ADDR_W  word address, addr[ADDR_W+1:2].
- Data_in  out  XLEN  memory write data.
- stall  in  1  memory busy (miss service).
- Data_out  in  XLEN  memory read data.

Behaviour:
- Reset:
  - All outputs are 0 and state is IDLE.
  - Reset asserted mid-transaction clears outputs on the same edge and abandons the access.
  - After reset, no write is issued until a new request arrives.
- Memory handshake:
  - A memory access completes on a rising edge where (MemRead|MemWrite)=1 and stall=0.
  - Data_out is sampled on that edge.
  - MemRead, MemWrite, WA and Data_in stay constant while stall=1.
  - MemRead and MemWrite are never high together.
- FSM states: IDLE, RD, RMW_RD, RMW_WR, WR, RESP.
  - IDLE, with req_valid=1:
    - Illegal funct3 -> err pulse next cycle, stay IDLE, no memory access.
    - Load -> RD.
    - SW -> WR.
    - SB/SH -> RMW_RD.
    - Request fields are latched on the accept edge.
  - RD: MemRead=1. On completion, latch the extended result into rdata and go to RESP.
  - RMW_RD: MemRead=1. On completion, merge wdata into the read word at the byte lane given by addr[1:0] (SH uses lanes addr[1]*2..+1), then go to RMW_WR.
  - RMW_WR: MemWrite=1, Data_in=merged word. On completion, go to RESP.
  - WR: MemWrite=1, Data_in=wdata. On completion, go to RESP.
  - RESP: done=1 for one cycle, then IDLE. busy=0 in RESP so a new request can be accepted in that cycle.
- busy = (state != IDLE && state != RESP).
- Latency with stall=0:
  - Load and SW: done 2 cycles after the accept edge.
  - SB/SH: done 3 cycles after the accept edge.
  - Each stall cycle adds 1 cycle.
- Load extension:
  - LB/LH sign-extend from bit 7/15 of the selected lane.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- req_valid while busy=1 is ignored; the requester must hold it.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, are treated as errors.
  - Behaviour matches illegal funct3: err pulse, no access, memory untouched.
- Undefined:
  - Low address bits are force-aligned: halfword lane uses addr[1], word ignores addr[1:0].
  - err fires only for illegal funct3.

Test Plan:
- Reset, then SW addr=0x10 wdata=0xDEADBEEF with stall=0:
  - WA=4, MemWrite high exactly 1 cycle.
  - done pulses 2 cycles after accept.
- LB addr=0x13 with memory word 0x80FF7F01 at WA=4:
  - rdata=0xFFFFFF80.
  - LBU at the same address returns 0x00000080.
  - LH addr=0x12 returns 0xFFFF80FF.
- SB addr=0x11 wdata=0xAA over word 0x11223344:
  - MemRead then MemWrite with Data_in=0x1122AA44.
  - done 3 cycles after accept.
- LW with stall held high for 5 cycles:
  - MemRead and WA held stable throughout.
  - done 7 cycles after accept.
  - rdata equals Data_out at the release edge.
- funct3=011:
  - err pulses once, MemRead=MemWrite=0, busy stays 0.
  - With LSU_MISALIGN_TRAP_EN, LW addr=0x02 gives the same result.
- RST asserted during RMW_RD with stall=1:
  - All outputs 0 immediately, no MemWrite afterward.
  - A subsequent LW completes normally.

Source files
------------

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: turns byte-addressed RISC-V loads/stores into 32-bit word
// accesses, with read-modify-write for SB/SH. Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
module lsu_mem_initiator #(
    parameter int ADDR_W = 10,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [XLEN-1:0]   wdata,
    output logic              busy,
    output logic              done,
    output logic [XLEN-1:0]   rdata,
    output logic              err,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] WA,
    output logic [XLEN-1:0]   Data_in,
    input  logic              stall,
    input  logic [XLEN-1:0]   Data_out
);

    typedef enum logic [2:0] {IDLE, RD, RMW_RD, RMW_WR, WR, RESP} state_t;

    state_t            state_q, state_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        off_q, off_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [ADDR_W-1:0] wa_q, wa_d;
    logic [XLEN-1:0]   data_q, data_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              accept, illegal, misalign, xfer;
    logic [7:0]        byte_lane;
    logic [15:0]       half_lane;
    logic [XLEN-1:0]   ext, merged;
    logic              unused_addr;

    assign unused_addr = ^addr[31:ADDR_W+2];

    assign busy     = (state_q != IDLE) && (state_q != RESP);
    assign done     = (state_q == RESP);
    assign MemRead  = (state_q == RD) || (state_q == RMW_RD);
    assign MemWrite = (state_q == RMW_WR) || (state_q == WR);
    assign WA       = wa_q;
    assign Data_in  = data_q;
    assign rdata    = rdata_q;
    assign err      = err_q;

    assign accept  = req_valid && !busy;
    assign illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
    assign xfer    = (MemRead || MemWrite) && !stall;

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
                      ((funct3 == 3'b010) && (addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // Halfword lane is picked by off[1] only, which force-aligns odd halfword addresses.
    always_comb begin
        byte_lane = Data_out[{off_q, 3'b000} +: 8];
        half_lane = Data_out[{off_q[1], 4'b0000} +: 16];
        case (f3_q)
            3'b000:  ext = {{(XLEN-8){byte_lane[7]}}, byte_lane};
            3'b001:  ext = {{(XLEN-16){half_lane[15]}}, half_lane};
            3'b100:  ext = {{(XLEN-8){1'b0}}, byte_lane};
            3'b101:  ext = {{(XLEN-16){1'b0}}, half_lane};
            default: ext = Data_out;
        endcase
        merged = Data_out;
        if (f3_q[1:0] == 2'b00) merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
        else                    merged[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    always_comb begin
        state_d = state_q;
        f3_d    = f3_q;
        off_d   = off_q;
        wdata_d = wdata_q;
        wa_d    = wa_q;
        data_d  = data_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE, RESP: begin
                state_d = IDLE;
                if (accept) begin
                    if (illegal || misalign) begin
                        err_d = 1'b1;
                    end else begin
                        f3_d    = funct3;
                        off_d   = addr[1:0];
                        wdata_d = wdata;
                        wa_d    = addr[ADDR_W+1:2];
                        if (!req_write) begin
                            state_d = RD;
                        end else if (funct3[1:0] == 2'b10) begin
                            data_d  = wdata;
                            state_d = WR;
                        end else begin
                            state_d = RMW_RD;
                        end
                    end
                end
            end
            RD: if (xfer) begin
                rdata_d = ext;
                state_d = RESP;
            end
            RMW_RD: if (xfer) begin
                data_d  = merged;
                state_d = RMW_WR;
            end
            RMW_WR, WR: if (xfer) state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            f3_q    <= '0;
            off_q   <= '0;
            wdata_q <= '0;
            wa_q    <= '0;
            data_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            wdata_q <= wdata_d;
            wa_q    <= wa_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Scoreboard bench for lsu_mem_initiator: word-array memory with random stall,
// behavioural reference model computing load results and store effects arithmetically.
module tb_lsu_mem_initiator;

    logic        clk, RST, req_valid, req_write, stall;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata, rdata, Data_in, Data_out;
    logic        busy, done, err, MemRead, MemWrite;
    logic [9:0]  WA;

    lsu_mem_initiator #(.ADDR_W(10), .XLEN(32)) dut (
        .clk(clk), .RST(RST), .req_valid(req_valid), .req_write(req_write),
        .funct3(funct3), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
        .rdata(rdata), .err(err), .MemRead(MemRead), .MemWrite(MemWrite),
        .WA(WA), .Data_in(Data_in), .stall(stall), .Data_out(Data_out)
    );

    typedef struct {
        bit          is_err;
        bit          chk_rd;
        logic [31:0] rd;
        int          t0;
        int          lat;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] mem[0:1023];
    logic [31:0] ref_mem[0:1023];
    int          checks = 0, errors = 0, cyc = 0, wr_cycles = 0;
    logic [9:0]  last_wa;
    logic [31:0] last_din;
    bit          rand_stall = 0, prev_hold = 0;
    logic [43:0] prev_bus;

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Memory side: combinational read, write on a completing MemWrite edge.
    assign Data_out = mem[WA];
    always @(posedge clk) if (!RST && MemWrite && !stall) mem[WA] = Data_in;
    always @(posedge clk) if (rand_stall) begin #1 stall = ($urandom_range(0, 3) == 0); end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] sext(input int v, input int bits);
        int r;
        r = v;
        if (v >= (1 << (bits - 1))) r = v - (1 << bits);
        return 32'(r);
    endfunction

    // Reference: loads compute the extended value, stores update ref_mem.
    function automatic void ref_req(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] wd, output bit is_err, output logic [31:0] rd);
        int idx, b, h, byte_v, half_v;
        logic [31:0] word;
        idx = int'(a[11:2]);
        b = int'(a[1:0]);
        h = int'(a[1]);
        word = ref_mem[idx];
        byte_v = int'((word >> (8 * b)) & 32'hFF);
        half_v = int'((word >> (16 * h)) & 32'hFFFF);
        is_err = (f3 == 3) || (f3 == 6) || (f3 == 7);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((f3 == 1 || f3 == 5) && a[0]) is_err = 1;
        if (f3 == 2 && a[1:0] != 0) is_err = 1;
`endif
        rd = 0;
        if (is_err) return;
        if (!wr) begin
            case (f3)
                0: rd = sext(byte_v, 8);
                1: rd = sext(half_v, 16);
                4: rd = 32'(byte_v);
                5: rd = 32'(half_v);
                default: rd = word;
            endcase
        end else if (f3[1:0] == 2'b10) begin
            ref_mem[idx] = wd;
        end else if (f3[1:0] == 2'b00) begin
            ref_mem[idx] = (word & ~(32'hFF << (8 * b))) | ((wd & 32'hFF) << (8 * b));
        end else begin
            ref_mem[idx] = (word & ~(32'hFFFF << (16 * h))) | ((wd & 32'hFFFF) << (16 * h));
        end
    endfunction

    task automatic setw(input int idx, input logic [31:0] v);
        mem[idx] = v;
        ref_mem[idx] = v;
    endtask

    task automatic do_req(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int lat, input bit push);
        int n = 0;
        exp_t e;
        @(negedge clk);
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            check("accept_timeout", 1, 0);
            return;
        end
        req_valid = 1; req_write = wr; funct3 = f3; addr = a; wdata = wd;
        if (push) begin
            ref_req(wr, f3, a, wd, e.is_err, e.rd);
            e.chk_rd = !wr && !e.is_err;
            e.t0 = cyc;
            e.lat = lat;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1 req_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sbq.size() != 0 || busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", n >= 500, 0);
    endtask

    // Monitor: pops one expectation per done/err pulse; also watches bus rules.
    always @(negedge clk) begin
        exp_t e;
        if (RST) begin
            prev_hold = 0;
        end else begin
            if (MemWrite) begin
                wr_cycles++;
                last_wa = WA;
                last_din = Data_in;
            end
            if (MemRead || MemWrite) check("rd_wr_exclusive", 64'(MemRead && MemWrite), 0);
            if (prev_hold) check("hold_stable_under_stall", 64'({MemRead, MemWrite, WA, Data_in}), 64'(prev_bus));
            prev_hold = (MemRead || MemWrite) && stall;
            prev_bus = {MemRead, MemWrite, WA, Data_in};
            if (err) begin
                if (sbq.size() == 0) check("unexpected_err", 1, 0);
                else begin
                    e = sbq.pop_front();
                    check("resp_is_err", 64'(e.is_err), 1);
                    if (e.lat >= 0) check("err_latency", 64'(cyc - e.t0), 64'(e.lat));
                    check("err_no_access", 64'({busy, MemRead, MemWrite}), 0);
                end
            end
            if (done) begin
                if (sbq.size() == 0) check("unexpected_done", 1, 0);
                else begin
                    e = sbq.pop_front();
                    check("resp_is_done", 64'(e.is_err), 0);
                    if (e.lat >= 0) check("done_latency", 64'(cyc - e.t0), 64'(e.lat));
                    if (e.chk_rd) check("rdata", 64'(rdata), 64'(e.rd));
                end
            end
        end
    end

    initial begin
        int lf[5] = '{0, 1, 2, 4, 5};
        int il[3] = '{3, 6, 7};
        logic [2:0]  f3;
        logic [31:0] a;
        int          bad;
        RST = 1; req_valid = 0; req_write = 0; funct3 = 0; addr = 0; wdata = 0; stall = 0;
        for (int i = 0; i < 1024; i++) setw(i, $urandom);
        repeat (3) @(negedge clk);
        check("reset_ctrl", 64'({busy, done, err, MemRead, MemWrite}), 0);
        check("reset_wa_din", 64'({WA, Data_in}), 0);
        check("reset_rdata", 64'(rdata), 0);
        #2 RST = 0;

        wr_cycles = 0;
        do_req(1, 3'b010, 32'h10, 32'hDEADBEEF, 2, 1);
        drain();
        check("sw_write_cycles", 64'(wr_cycles), 1);
        check("sw_wa", 64'(last_wa), 4);
        check("sw_mem", 64'(mem[4]), 64'h DEADBEEF);

        setw(4, 32'h80FF7F01);
        do_req(0, 3'b000, 32'h13, 0, 2, 1); drain();
        check("lb_const", 64'(rdata), 64'hFFFFFF80);
        do_req(0, 3'b100, 32'h13, 0, 2, 1); drain();
        check("lbu_const", 64'(rdata), 64'h00000080);
        do_req(0, 3'b001, 32'h12, 0, 2, 1); drain();
        check("lh_const", 64'(rdata), 64'hFFFF80FF);

        setw(4, 32'h11223344);
        do_req(1, 3'b000, 32'h11, 32'hAA, 3, 1); drain();
        check("sb_data_in", 64'(last_din), 64'h1122AA44);
        check("sb_mem", 64'(mem[4]), 64'h1122AA44);

        stall = 1;
        do_req(0, 3'b010, 32'h10, 0, 7, 1);
        repeat (5) @(posedge clk);
        #1 stall = 0;
        drain();
        check("lw_stall_rdata", 64'(rdata), 64'h1122AA44);

        do_req(0, 3'b011, 32'h20, 0, 1, 1); drain();
`ifdef LSU_MISALIGN_TRAP_EN
        do_req(0, 3'b010, 32'h02, 0, 1, 1); drain();
`endif

        // Reset while an SB is stalled in its read phase: the store must vanish.
        stall = 1;
        wr_cycles = 0;
        do_req(1, 3'b000, 32'h40, 32'h55, -1, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 RST = 1;
        #1;
        check("midrst_ctrl", 64'({busy, done, err, MemRead, MemWrite}), 0);
        check("midrst_wa_din", 64'({WA, Data_in}), 0);
        check("midrst_rdata", 64'(rdata), 0);
        stall = 0;
        @(negedge clk);
        #2 RST = 0;
        do_req(0, 3'b010, 32'h10, 0, 2, 1); drain();
        check("post_rst_lw", 64'(rdata), 64'h1122AA44);
        check("post_rst_no_write", 64'(wr_cycles), 0);

        rand_stall = 1;
        for (int i = 0; i < 300; i++) begin
            f3 = ($urandom_range(0, 9) == 0) ? 3'(il[$urandom_range(0, 2)]) : 3'(lf[$urandom_range(0, 4)]);
            a = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 63));
            do_req(1'($urandom_range(0, 1)), f3, a, $urandom, -1, 1);
        end
        drain();
        rand_stall = 0;
        @(posedge clk);
        #2 stall = 0;

        bad = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
        check("final_mem_mismatch_words", 64'(bad), 0);
        check("scoreboard_empty", 64'(sbq.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
